// File: rtl/rv32i_types.sv
// rv32i_types: shared pipeline register layouts and memory-stage enums.
package rv32i_types;
  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;
  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } mem_state_t;
  typedef struct packed {
    logic       valid;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic [3:0] regfilemux_sel;
  } ctrl_word_t;
  typedef struct packed {
    ctrl_word_t  ctrl_wd;
    logic [31:0] alu_out;
    logic        cmp_out;
    logic [31:0] u_imm;
    logic [4:0]  rd;
    logic [31:0] mar;
    logic [31:0] mem_data_out;
  } EX_MEM_stage_t;
  typedef struct packed {
    ctrl_word_t  ctrl_wd;
    logic [31:0] alu_out;
    logic        cmp_out;
    logic [31:0] u_imm;
    logic [4:0]  rd;
    logic [31:0] mdr;
  } MEM_WB_stage_t;
endpackage

// File: rtl/mem_stage_store_align.sv
// store_align: byte enables and lane-shifted store data for sb/sh/sw.
module store_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o
);
  assign wmask_o = funct3_i == sw ? 4'b1111 :
                   funct3_i == sh ? 4'b0011 << {off_i[1], 1'b0} :
                   funct3_i == sb ? 4'b0001 << off_i : 4'b0000;
  assign wdata_o = data_i << {off_i, 3'b000};
endmodule

// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage; DONE parks a finished access while fetch is frozen.
module mem_stage
  import rv32i_types::*;
(
  input  logic          clk,
  input  logic          rst,
  input  EX_MEM_stage_t ex_mem_in,
  input  logic          imem_stall,
  input  logic [31:0]   dmem_rdata,
  input  logic          dmem_resp,
  output logic [31:0]   dmem_address,
  output logic          dmem_read,
  output logic          dmem_write,
  output logic [3:0]    dmem_wmask,
  output logic [31:0]   dmem_wdata,
  output logic          mem_stall,
  output MEM_WB_stage_t mem_wb_out
);
  mem_state_t    state_q, state_d;
  logic [31:0]   rdata_buf_q, rdata_buf_d;
  MEM_WB_stage_t mem_wb_d;
  logic          memop, idle, capture;
  assign memop = ex_mem_in.ctrl_wd.valid & (ex_mem_in.ctrl_wd.mem_read | ex_mem_in.ctrl_wd.mem_write);
  assign idle = state_q == IDLE;
  assign dmem_read = idle & memop & ex_mem_in.ctrl_wd.mem_read;
  assign dmem_write = idle & memop & ex_mem_in.ctrl_wd.mem_write;
  assign mem_stall = memop & ~dmem_resp & idle;
  assign dmem_address = {ex_mem_in.mar[31:2], 2'b00};
  assign capture = idle & memop & dmem_resp & imem_stall;
  store_align u_store_align (
    .funct3_i(ex_mem_in.ctrl_wd.funct3),
    .off_i   (ex_mem_in.mar[1:0]),
    .data_i  (ex_mem_in.mem_data_out),
    .wmask_o (dmem_wmask),
    .wdata_o (dmem_wdata)
  );
  // A response that lands while fetch is frozen is parked so it is not re-requested.
  always_comb begin
    state_d = idle ? (capture ? DONE : IDLE) : (imem_stall ? DONE : IDLE);
    rdata_buf_d = capture ? dmem_rdata : rdata_buf_q;
    mem_wb_d = imem_stall ? mem_wb_out :
               mem_stall  ? MEM_WB_stage_t'('0) :
               MEM_WB_stage_t'{ctrl_wd: ex_mem_in.ctrl_wd, alu_out: ex_mem_in.alu_out,
                               cmp_out: ex_mem_in.cmp_out, u_imm: ex_mem_in.u_imm,
                               rd: ex_mem_in.rd, mdr: idle ? dmem_rdata : rdata_buf_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_buf_q <= '0;
      mem_wb_out <= '0;
    end else begin
      state_q <= state_d;
      rdata_buf_q <= rdata_buf_d;
      mem_wb_out <= mem_wb_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_stage;
  import rv32i_types::*;
  logic          clk = 1'b0;
  logic          rst, imem_stall, dmem_resp;
  logic [31:0]   dmem_rdata;
  EX_MEM_stage_t ex;
  logic [31:0]   dmem_address, dmem_wdata;
  logic          dmem_read, dmem_write, mem_stall;
  logic [3:0]    dmem_wmask;
  MEM_WB_stage_t wb;
  int checks = 0, errors = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_mem_in(ex), .imem_stall(imem_stall),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_address(dmem_address),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .mem_stall(mem_stall), .mem_wb_out(wb)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [1:0] off);
    int o = int'(off);
    if (f3 == 3'd2) return 4'hF;
    if (f3 == 3'd1) return (o >= 2) ? 4'hC : 4'h3;
    if (f3 == 3'd0) return 4'(2 ** o);
    return 4'h0;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] off);
    logic [63:0] p = {32'b0, d} * (64'd1 << (8 * int'(off)));
    return p[31:0];
  endfunction

  task automatic drive(input logic v, mr, mw, input logic [2:0] f3,
                       input logic [31:0] mar, data, alu, input logic [4:0] rd);
    ex = '0;
    ex.ctrl_wd.valid = v;
    ex.ctrl_wd.load_regfile = v & ~mw;
    ex.ctrl_wd.mem_read = mr;
    ex.ctrl_wd.mem_write = mw;
    ex.ctrl_wd.funct3 = f3;
    ex.ctrl_wd.regfilemux_sel = {3'b0, mr};
    ex.mar = mar;
    ex.mem_data_out = data;
    ex.alu_out = alu;
    ex.u_imm = alu ^ 32'h5A5A_5A5A;
    ex.cmp_out = alu[0];
    ex.rd = rd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; imem_stall = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick; tick;
    checks++; if (wb !== '0) begin errors++; $display("FAIL reset_wb got %h exp 0", wb); end
    checks++; if ({dmem_read, dmem_write, mem_stall} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {dmem_read, dmem_write, mem_stall}); end
    rst = 1'b0;
  endtask

  task automatic test_sw;
    int stalls = 0;
    drive(1'b1, 1'b0, 1'b1, sw, 32'h100, 32'hDEAD_BEEF, 32'h100, 5'd5);
    for (int i = 0; i < 4; i++) begin
      dmem_resp = (i == 3);
      #1;
      checks++; if ({dmem_address, dmem_wmask, dmem_wdata, dmem_write, dmem_read} !== {32'h100, 4'hF, 32'hDEAD_BEEF, 2'b10})
        begin errors++; $display("FAIL sw_req cyc%0d got a=%h m=%b d=%h w=%b r=%b", i, dmem_address, dmem_wmask, dmem_wdata, dmem_write, dmem_read); end
      if (mem_stall) stalls++;
      tick;
      checks++; if (wb.ctrl_wd.valid !== (i == 3)) begin errors++; $display("FAIL sw_wb_valid cyc%0d got %b exp %b", i, wb.ctrl_wd.valid, i == 3); end
    end
    checks++; if (wb.alu_out !== 32'h100 || wb.rd !== 5'd5) begin errors++; $display("FAIL sw_wb got alu=%h rd=%0d exp 100/5", wb.alu_out, wb.rd); end
    checks++; if (stalls != 3) begin errors++; $display("FAIL sw_stall_cycles got %0d exp 3", stalls); end
    dmem_resp = 1'b0;
  endtask

  task automatic test_sub_word;
    dmem_resp = 1'b1;
    drive(1'b1, 1'b0, 1'b1, sb, 32'h103, 32'h0000_00AB, 32'h103, 5'd6);
    #1;
    checks++; if ({dmem_address, dmem_wmask, dmem_wdata, mem_stall} !== {32'h100, 4'b1000, 32'hAB00_0000, 1'b0})
      begin errors++; $display("FAIL sb_align got a=%h m=%b d=%h st=%b", dmem_address, dmem_wmask, dmem_wdata, mem_stall); end
    tick;
    drive(1'b1, 1'b0, 1'b1, sh, 32'h102, 32'h0000_1234, 32'h102, 5'd6);
    #1;
    checks++; if ({dmem_wmask, dmem_wdata} !== {4'b1100, 32'h1234_0000})
      begin errors++; $display("FAIL sh_align got m=%b d=%h exp 1100/12340000", dmem_wmask, dmem_wdata); end
    tick;
    checks++; if (wb.alu_out !== 32'h102 || !wb.ctrl_wd.valid) begin errors++; $display("FAIL sh_wb got alu=%h v=%b", wb.alu_out, wb.ctrl_wd.valid); end
    dmem_resp = 1'b0;
  endtask

  task automatic test_lw_done;
    int reads = 0;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h204, 5'd7);
    imem_stall = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin dmem_resp = 1'b0; dmem_rdata = 32'hFFFF_FFFF; end
      if (i == 2) imem_stall = 1'b0;
      #1;
      reads += int'(dmem_read);
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lw_stall cyc%0d got %b exp 0", i, mem_stall); end
      tick;
      if (i < 2) begin
        checks++; if (wb.alu_out !== 32'h102) begin errors++; $display("FAIL lw_hold cyc%0d got %h exp 102", i, wb.alu_out); end
      end
    end
    checks++; if ({wb.ctrl_wd.valid, wb.mdr, wb.alu_out} !== {1'b1, 32'h1234_5678, 32'h204})
      begin errors++; $display("FAIL lw_release got v=%b mdr=%h alu=%h", wb.ctrl_wd.valid, wb.mdr, wb.alu_out); end
    checks++; if (reads != 1) begin errors++; $display("FAIL lw_read_pulses got %0d exp 1", reads); end
    dmem_rdata = 32'h0;
  endtask

  task automatic test_alu;
    logic [31:0] a = $urandom;
    logic [4:0]  r = 5'($urandom_range(1, 31));
    drive(1'b1, 1'b0, 1'b0, 3'd0, $urandom, $urandom, a, r);
    #1;
    checks++; if ({dmem_read, dmem_write, mem_stall} !== 3'b000) begin errors++; $display("FAIL alu_noreq got %b exp 000", {dmem_read, dmem_write, mem_stall}); end
    tick;
    checks++; if ({wb.ctrl_wd.valid, wb.alu_out, wb.rd, wb.u_imm} !== {1'b1, a, r, a ^ 32'h5A5A_5A5A})
      begin errors++; $display("FAIL alu_wb got v=%b alu=%h rd=%0d exp alu=%h rd=%0d", wb.ctrl_wd.valid, wb.alu_out, wb.rd, a, r); end
  endtask

  task automatic test_bubble;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h300, 5'd9);
    dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL bubble_stall cyc%0d got %b exp 1", i, mem_stall); end
      tick;
      checks++; if ({wb.ctrl_wd.valid, wb.ctrl_wd.load_regfile} !== 2'b00) begin errors++; $display("FAIL bubble_wb cyc%0d got %b exp 00", i, {wb.ctrl_wd.valid, wb.ctrl_wd.load_regfile}); end
    end
    dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick;
    checks++; if ({wb.ctrl_wd.valid, wb.mdr} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL bubble_release got v=%b mdr=%h", wb.ctrl_wd.valid, wb.mdr); end
    dmem_resp = 1'b0;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b0, 1'b1, sh, 32'h402, 32'h0000_BEEF, 32'h402, 5'd3);
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (wb !== '0) begin errors++; $display("FAIL rstmid_wb got %h exp 0", wb); end
    checks++; if ({dmem_read, dmem_write} !== 2'b00) begin errors++; $display("FAIL rstmid_strobes got %b exp 00", {dmem_read, dmem_write}); end
    tick;
    // Park a load in DONE, then reset: the next load must be requested again.
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h500, 5'd4);
    imem_stall = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
    tick;
    dmem_resp = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0; imem_stall = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h3333_4444;
    #1;
    checks++; if (dmem_read !== 1'b1) begin errors++; $display("FAIL rstmid_state got read=%b exp 1", dmem_read); end
    tick;
    checks++; if (wb.mdr !== 32'h3333_4444) begin errors++; $display("FAIL rstmid_mdr got %h exp 33334444", wb.mdr); end
    dmem_resp = 1'b0;
  endtask

  task automatic test_random;
    MEM_WB_stage_t exp_wb = '0;
    logic exp_bubble = 1'b0, have = 1'b0, served = 1'b0, req;
    logic [31:0] buf_word = '0;
    logic v, mr, mw;
    logic [2:0] f3;
    rst = 1'b1; tick; rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!have) begin
        int kind = $urandom_range(0, 2);
        v = ($urandom_range(0, 3) != 0);
        mr = (kind == 1); mw = (kind == 2);
        f3 = mw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
        drive(v, mr, mw, f3, $urandom, $urandom, $urandom, 5'($urandom));
        have = 1'b1;
      end
      req = v && (mr || mw) && !served;
      imem_stall = ($urandom_range(0, 3) == 0);
      dmem_resp = req && ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
      #1;
      checks++; if ({dmem_read, dmem_write, mem_stall} !== {req & mr, req & mw, req & ~dmem_resp})
        begin errors++; $display("FAIL rand_strobes cyc%0d got %b exp %b", c, {dmem_read, dmem_write, mem_stall}, {req & mr, req & mw, req & ~dmem_resp}); end
      if (req && mw) begin
        checks++; if ({dmem_address, dmem_wmask, dmem_wdata} !== {ex.mar & 32'hFFFF_FFFC, ref_mask(f3, ex.mar[1:0]), ref_wdata(ex.mem_data_out, ex.mar[1:0])})
          begin errors++; $display("FAIL rand_store cyc%0d got a=%h m=%b d=%h", c, dmem_address, dmem_wmask, dmem_wdata); end
      end
      if (imem_stall) begin
        if (req && dmem_resp) begin served = 1'b1; buf_word = dmem_rdata; end
      end else if (req && !dmem_resp) begin
        exp_bubble = 1'b1;
      end else begin
        exp_bubble = 1'b0;
        exp_wb = '{ctrl_wd: ex.ctrl_wd, alu_out: ex.alu_out, cmp_out: ex.cmp_out,
                   u_imm: ex.u_imm, rd: ex.rd, mdr: served ? buf_word : dmem_rdata};
        served = 1'b0; have = 1'b0;
      end
      tick;
      if (exp_bubble) begin
        checks++; if ({wb.ctrl_wd.valid, wb.ctrl_wd.load_regfile} !== 2'b00) begin errors++; $display("FAIL rand_bubble cyc%0d got %b exp 00", c, {wb.ctrl_wd.valid, wb.ctrl_wd.load_regfile}); end
      end else begin
        checks++; if (wb !== exp_wb) begin errors++; $display("FAIL rand_wb cyc%0d got %h exp %h", c, wb, exp_wb); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_sw;
    test_sub_word;
    test_lw_done;
    test_alu;
    test_bubble;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port ex_mem_in  input  EX_MEM_stage_t  EX/MEM pipeline register contents.
REQ-004 SHALL have port imem_stall  input  1  global freeze from instruction-fetch miss.
REQ-005 SHALL have port dmem_rdata  input  32  data memory read word.
REQ-006 SHALL have port dmem_resp  input  1  data memory completion, one-cycle pulse.
REQ-007 SHALL have port dmem_address  output  32  word-aligned address, {mar[31:2],2'b00}.
REQ-008 SHALL have ports dmem_read / dmem_write  output  1 each  request strobes.
REQ-009 SHALL have ports dmem_wmask  output  4  and dmem_wdata  output  32  byte enables and lane-shifted store data.
REQ-010 SHALL have port mem_stall  output  1  freeze request to IF/ID/EX.
REQ-011 SHALL have port mem_wb_out  output  MEM_WB_stage_t  MEM/WB pipeline register.

Function
REQ-012 SHALL define memop = ctrl_wd.valid & (mem_read | mem_write); mem_read and mem_write are never both set.
REQ-013 SHALL implement FSM states IDLE, DONE; reset state IDLE.
REQ-014 IDLE: dmem_read/dmem_write SHALL equal mem_read/mem_write when memop is set, else 0; address, wmask and wdata SHALL stay stable until dmem_resp.
REQ-015 IDLE, dmem_resp=1, imem_stall=1: SHALL capture dmem_rdata into rdata_buf and go DONE.
REQ-016 DONE: SHALL drive no request; SHALL return to IDLE on the first cycle imem_stall=0.
REQ-017 mem_stall SHALL equal memop & ~dmem_resp & (state==IDLE), combinationally.
REQ-018 advance = ~mem_stall & ~imem_stall; on advance, mem_wb_out SHALL load ctrl_wd, alu_out, cmp_out, u_imm and rd from ex_mem_in.
REQ-019 mem_wb_out.mdr SHALL be the raw word: dmem_rdata in IDLE, rdata_buf in DONE; byte/half extraction belongs to WB via regfilemux_sel.
REQ-020 When imem_stall=1, mem_wb_out SHALL hold its value.
REQ-021 When mem_stall=1 and imem_stall=0, mem_wb_out SHALL load a bubble: ctrl_wd.valid=0, load_regfile=0.
REQ-022 off = mar[1:0]; wmask SHALL be: sw 4'b1111; sh 4'b0011<<(2*off[1]); sb 4'b0001<<off.
REQ-023 wdata SHALL be mem_data_out << (8*off), truncated to 32 bits.
REQ-024 Non-memop or invalid instructions SHALL pass through with zero latency and no memory request.
REQ-025 A completed access SHALL never be re-issued while held in DONE.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, rdata_buf=0, mem_wb_out=all zeros (valid=0, load_regfile=0).
REQ-027 Reset mid-access SHALL abandon the request; request strobes SHALL be 0 in the cycle after reset when ctrl_wd.valid=0.

Structure
REQ-028 EX_MEM_stage_t, MEM_WB_stage_t, store_funct3_t and the mem-stage state enum SHALL live in the shared rv32i_types package.
REQ-029 Store-lane alignment (wmask, wdata) SHALL be one combinational sub-module, store_align.

Verification
REQ-030 Verification SHALL cover: sw, mar=0x100, data=0xDEADBEEF, resp after 3 cycles -> address 0x100, wmask 1111, wdata 0xDEADBEEF, mem_stall high for 3 cycles, then one valid MEM/WB entry.
REQ-031 Verification SHALL cover: sb, mar=0x103, data=0x000000AB -> wmask 1000, wdata 0xAB000000, address 0x100.
REQ-032 Verification SHALL cover: lw, mar=0x204, rdata=0x12345678, resp same cycle as imem_stall=1 for 2 cycles -> DONE; one read pulse only; mdr=0x12345678 on release.
REQ-033 Verification SHALL cover: ALU op, valid=1, no memop -> no request, mem_stall=0, MEM/WB updated next edge.
REQ-034 Verification SHALL cover: lw pending, mem_stall=1, imem_stall=0 -> bubble (valid=0) written each stalled cycle.
REQ-035 Verification SHALL cover: rst asserted during pending sh -> next cycle state IDLE, mem_wb_out zero, no write completes.
